// File: rtl/add4_serial_pkg.sv
// Shared definitions for the serial operand accumulator: default sizing
// and the two-state controller encoding.
package add4_serial_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_OPS = 4;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

endpackage : add4_serial_pkg

// File: rtl/add4_acc_stage.sv
// WIDTH-bit accumulator register with adder, carry-out, clear and enable.
// The carry output reflects the addition that would be stored this cycle.
module add4_acc_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] add_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   sum_full;

    // Full-precision add so the carry-out is available for the sticky flag.
    always_comb begin
        sum_full = {1'b0, acc_q} + {1'b0, add_i};
        carry_o  = sum_full[WIDTH];
        acc_d    = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_full[WIDTH-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule : add4_acc_stage

// File: rtl/add4_serial.sv
// Serial adder: takes NUM_OPS operands one per accepted handshake, then
// presents {ov, sum} until the consumer takes it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_ACCUM | taking operands, in_ready=1, out_valid=0
//   ST_DONE  | result held on sum/ov, in_ready=0, out_valid=1
module add4_serial
    import add4_serial_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ov_o,
    output logic [3:0]       op_cnt_o
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_OPS - 1);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             ov_q;
    logic             ov_d;
    logic [3:0]       op_cnt_q;
    logic             accept;
    logic             consume;
    logic             carry;
    logic [WIDTH-1:0] add_d;

    // Handshake qualifiers; operand is forced to zero unless accepted so no
    // state or output ever sees in_data while in_valid is low.
    always_comb begin
        accept  = in_valid_i & in_ready_q;
        consume = out_valid_q & out_ready_i;
        add_d   = accept ? in_data_i : '0;
        ov_d    = ov_q | carry;
    end

    add4_acc_stage #(
        .WIDTH(WIDTH)
    ) u_acc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (consume),
        .en_i   (accept),
        .add_i  (add_d),
        .acc_o  (sum_o),
        .carry_o(carry)
    );

    // Controller: operand counting, sticky overflow and registered handshakes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_cnt_q    <= '0;
            ov_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        ov_q <= ov_d;
                        if (op_cnt_q == LAST_CNT) begin
                            op_cnt_q    <= '0;
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            op_cnt_q <= op_cnt_q + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (consume) begin
                        ov_q        <= 1'b0;
                        state_q     <= ST_ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign ov_o        = ov_q;
    assign op_cnt_o    = op_cnt_q;

endmodule : add4_serial
